// File: rtl/alu_issue.sv
// Issue stage feeding the combinational MIPS ALU: decode, operand select and a 2-entry skid buffer.
// Optional build macro ALU_ISSUE_ILLEGAL_DROP_EN drops illegal instructions and counts them.
module alu_issue #(
    parameter logic [5:0]  ILLEGAL_FUNC = 6'd0,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      operand_a,
    output logic [31:0]      operand_b,
    output logic [5:0]       func,
    output logic [4:0]       dest_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    // Entry layout: {operand_a, operand_b, func, dest_reg, illegal}
    localparam int unsigned ENT_W = 76;
    localparam logic [ENT_W-1:0] ENT_RESET = {32'd0, 32'd0, ILLEGAL_FUNC, 5'd0, 1'b0};

    logic [1:0]       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] skid_q, skid_d;

    logic [5:0]       opcode, funct;
    logic [15:0]      imm;
    logic [5:0]       dec_func;
    logic [31:0]      dec_b;
    logic [4:0]       dec_dest;
    logic             dec_illegal;
    logic [ENT_W-1:0] dec_entry;

    logic             accept, retire, enq;
    logic             unused_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        dec_func    = ILLEGAL_FUNC;
        dec_b       = rt_val;
        dec_dest    = '0;
        dec_illegal = 1'b1;
        case (opcode)
            6'd0: begin
                if (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 ||
                    funct == 6'd37 || funct == 6'd43) begin
                    dec_func    = funct;
                    dec_dest    = instr[15:11];
                    dec_illegal = 1'b0;
                end
            end
            6'd8: begin
                dec_func    = 6'd32;
                dec_b       = {{16{imm[15]}}, imm};
                dec_dest    = instr[20:16];
                dec_illegal = 1'b0;
            end
            6'd12: begin
                dec_func    = 6'd36;
                dec_b       = {16'd0, imm};
                dec_dest    = instr[20:16];
                dec_illegal = 1'b0;
            end
            6'd13: begin
                dec_func    = 6'd37;
                dec_b       = {16'd0, imm};
                dec_dest    = instr[20:16];
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    assign dec_entry = {rs_val, dec_b, dec_func, dec_dest, dec_illegal};

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign retire    = out_valid & out_ready;

`ifdef ALU_ISSUE_ILLEGAL_DROP_EN
    assign enq = accept & ~dec_illegal;
`else
    assign enq = accept;
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (enq) begin
                        head_d  = dec_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (enq && retire) begin
                        head_d = dec_entry;
                    end else if (enq) begin
                        skid_d  = dec_entry;
                        state_d = TWO;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (retire) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= ENT_RESET;
            skid_q     <= ENT_RESET;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    assign operand_a = head_q[75:44];
    assign operand_b = head_q[43:12];
    assign func      = head_q[11:6];
    assign dest_reg  = head_q[5:1];

`ifdef ALU_ISSUE_ILLEGAL_DROP_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Dropped illegals on a flush cycle are discarded with the rest of that cycle's accept.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && dec_illegal && !flush && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal       = 1'b0;
    assign illegal_count = cnt_q;
    logic unused_head_ill;
    assign unused_head_ill = head_q[0];
`else
    assign illegal       = head_q[0];
    assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: driver pushes model results, negedge monitor pops on retire.
// Honours ALU_ISSUE_ILLEGAL_DROP_EN when the design is built with it.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [5:0]  func;
    logic [4:0]  dest_reg;
    logic        illegal;
    logic [7:0]  illegal_count;

    int checks   = 0;
    int failures = 0;
    logic [75:0] sb_q[$];
    int model_cnt = 0;

    alu_issue #(.ILLEGAL_FUNC(6'd0), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_a(operand_a), .operand_b(operand_b), .func(func),
        .dest_reg(dest_reg), .illegal(illegal), .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [75:0] cur_out();
        return {operand_a, operand_b, func, dest_reg, illegal};
    endfunction

    // Reference: the ALU-facing result implied by the instruction's meaning.
    function automatic logic [75:0] ref_issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        int unsigned op;
        int unsigned fn;
        logic [15:0] imm;
        logic [31:0] sext;
        logic [31:0] zext;
        op   = int'(i >> 26);
        fn   = i % 64;
        imm  = i[15:0];
        sext = 32'($signed(imm));
        zext = 32'(imm);
        if (op == 0 && (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 43))
            return {rs, rt, 6'(fn), i[15:11], 1'b0};
        if (op == 8)  return {rs, sext, 6'd32, i[20:16], 1'b0};
        if (op == 12) return {rs, zext, 6'd36, i[20:16], 1'b0};
        if (op == 13) return {rs, zext, 6'd37, i[20:16], 1'b0};
        return {rs, rt, 6'd0, 5'd0, 1'b1};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] legal_fn[5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd43};
        logic [5:0] bad_fn[5]   = '{6'd0, 6'd24, 6'd26, 6'd33, 6'd42};
        logic [5:0] bad_op[6]   = '{6'd2, 6'd4, 6'd9, 6'd15, 6'd35, 6'd43};
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return {6'd0, r[25:6], legal_fn[$urandom_range(0, 4)]};
            1: return {6'd0, r[25:6], bad_fn[$urandom_range(0, 4)]};
            2: return {6'd8, r[25:0]};
            3: return {6'd12, r[25:0]};
            4: return {6'd13, r[25:0]};
            default: return {bad_op[$urandom_range(0, 5)], r[25:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] rs,
                        input logic [31:0] rt, input logic ordy, input logic fl);
        logic [75:0] e;
        @(posedge clk);
        #1;
        in_valid  = v;
        instr     = i;
        rs_val    = rs;
        rt_val    = rt;
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            sb_q.delete();
        end else if (v && in_ready) begin
            e = ref_issue(i, rs, rt);
`ifdef ALU_ISSUE_ILLEGAL_DROP_EN
            if (e[0]) begin
                if (model_cnt < 255) model_cnt++;
            end else begin
                sb_q.push_back(e);
            end
`else
            sb_q.push_back(e);
`endif
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid_ready"}, {74'd0, out_valid, in_ready}, {74'd0, 1'b0, 1'b1});
        chk({name, "_data"}, cur_out(), 76'd0);
        chk({name, "_count"}, {68'd0, illegal_count}, 76'd0);
    endtask

    // Monitor: retire comparison plus hold-stability while stalled.
    logic        hold;
    logic [75:0] snap;
    initial begin
        hold = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) chk("stall_stable", cur_out(), snap);
                hold = 1'b0;
                if (out_valid && !out_ready && !flush) begin
                    hold = 1'b1;
                    snap = cur_out();
                end
                if (out_valid && out_ready && !flush) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out actual=%h required=none", cur_out());
                    end else begin
                        chk("retire_entry", cur_out(), sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_val = '0; rt_val = '0;
        out_ready = 1'b0; flush = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("add_out", {75'd0, out_valid}, 76'd1);
        chk("add_data", cur_out(), {32'd5, 32'd7, 6'd32, 5'd3, 1'b0});

        step(1'b1, 32'h2085FFFF, 32'd10, 32'd99, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("addi_data", cur_out(), {32'd10, 32'hFFFFFFFF, 6'd32, 5'd5, 1'b0});
        step(1'b1, 32'h34858000, 32'd3, 32'd99, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("ori_data", cur_out(), {32'd3, 32'h00008000, 6'd37, 5'd5, 1'b0});

        // Three beats into a stalled stage: only two fit.
        step(1'b1, 32'h00221820, 32'd11, 32'd22, 1'b0, 1'b0);
        step(1'b1, 32'h34858000, 32'h100, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h2085FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("full_in_ready", {75'd0, in_ready}, 76'd0);
        chk("full_head", cur_out(), {32'd11, 32'd22, 6'd32, 5'd3, 1'b0});
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("full_head_held", cur_out(), {32'd11, 32'd22, 6'd32, 5'd3, 1'b0});
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("after_retire_in_ready", {75'd0, in_ready}, 76'd1);
        chk("second_head", cur_out(), {32'h100, 32'h8000, 6'd37, 5'd5, 1'b0});
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("drained_valid", {75'd0, out_valid}, 76'd0);

        step(1'b1, 32'h00220018, 32'd3, 32'd4, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_DROP_EN
        chk("mult_dropped", {75'd0, out_valid}, 76'd0);
        chk("mult_count", {68'd0, illegal_count}, 76'd1);
        for (int k = 0; k < 299; k++) step(1'b1, 32'h00220018, 32'd3, 32'd4, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("count_saturate", {68'd0, illegal_count}, 76'd255);
`else
        chk("mult_valid", {75'd0, out_valid}, 76'd1);
        chk("mult_data", cur_out(), {32'd3, 32'd4, 6'd0, 5'd0, 1'b1});
`endif

        // Flush with the buffer full and a beat on the input.
        step(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b0);
        step(1'b1, 32'h34858000, 32'd5, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h2085FFFF, 32'd7, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("flush_state", {74'd0, out_valid, in_ready}, {74'd0, 1'b0, 1'b1});
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("flush_nothing_emerges", {75'd0, out_valid}, 76'd0);

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("drain_queue_empty", 76'(sb_q.size()), 76'd0);
        chk("drain_valid", {75'd0, out_valid}, 76'd0);
`ifdef ALU_ISSUE_ILLEGAL_DROP_EN
        chk("random_count", {68'd0, illegal_count}, 76'(model_cnt));
`else
        chk("count_tied", {68'd0, illegal_count}, 76'd0);
`endif

        // Asynchronous reset while an entry is held.
        step(1'b1, 32'h00221820, 32'd9, 32'd8, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("pre_reset_valid", {75'd0, out_valid}, 76'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        model_cnt = 0;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("post_reset", {74'd0, out_valid, in_ready}, {74'd0, 1'b0, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
